// File: rtl/tetris_pkg.sv
// Shared playfield definitions: field geometry, line-clear FSM encoding and
// the row-slice convention used by the merge and line-clear stages.
package tetris_pkg;

    localparam int FIELD_W    = 20;
    localparam int FIELD_H    = 20;
    localparam int FIELD_BITS = FIELD_W * FIELD_H;

    // Row pointer and cleared-line counter widths (both hold 0..FIELD_H).
    localparam int PTR_W = 5;
    localparam int CNT_W = 5;

    // Line-clear controller states.
    typedef enum logic [1:0] {
        LC_IDLE = 2'd0,
        LC_SCAN = 2'd1,
        LC_DONE = 2'd2
    } lc_state_t;

    // Row r of a field lives at [r*FIELD_W +: FIELD_W]; row 0 is the top
    // row and bit c of a row is column c.
    function automatic logic [FIELD_W-1:0] field_row(
        input logic [FIELD_BITS-1:0] fld,
        input int                    r
    );
        return fld[r*FIELD_W +: FIELD_W];
    endfunction

endpackage

// File: rtl/field_row_collapse.sv
// Combinational row test and collapse for the line-clear engine. Reports
// whether row ptr is full, and produces the field with row ptr removed:
// every row at or above ptr drops by one and a zero row enters at the top.
module field_row_collapse
    import tetris_pkg::*;
#(
    parameter int WIDTH  = FIELD_W,
    parameter int HEIGHT = FIELD_H
) (
    input  logic [WIDTH*HEIGHT-1:0] fld,
    input  logic [PTR_W-1:0]        ptr,
    output logic                    row_full,
    output logic [WIDTH*HEIGHT-1:0] fld_collapsed
);

    // Full-row detect on the row selected by ptr; an out-of-range ptr is never full.
    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (PTR_W'(r) == ptr) begin
                row_full = &fld[r*WIDTH +: WIDTH];
            end
        end
    end

    // Shift mux: rows below ptr stay put, rows 1..ptr take the row above,
    // and row 0 always refills with zeros.
    always_comb begin
        fld_collapsed = fld;
        fld_collapsed[0 +: WIDTH] = '0;
        for (int r = 1; r < HEIGHT; r++) begin
            if (PTR_W'(r) <= ptr) begin
                fld_collapsed[r*WIDTH +: WIDTH] = fld[(r-1)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/field_line_clear.sv
// Post-lock line-clear engine. Scans the merged field bottom-up one row per
// cycle, removes every full row and returns the compacted field together
// with the number of rows removed.
//
// Handshake: start is sampled only while idle (busy=0, done=0); it is
// ignored at all other times and never queued. busy is high for the whole
// scan, and done pulses for exactly one cycle with busy low; field_out and
// lines_cleared are valid in that cycle and hold until the next done.
module field_line_clear
    import tetris_pkg::*;
#(
    parameter int WIDTH  = FIELD_W,
    parameter int HEIGHT = FIELD_H
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH*HEIGHT-1:0] field_in,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*HEIGHT-1:0] field_out,
    output logic [CNT_W-1:0]        lines_cleared,
    output lc_state_t               o_dbg_state
);

    lc_state_t               r_state;
    logic [WIDTH*HEIGHT-1:0] r_fld;
    logic [PTR_W-1:0]        r_ptr;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [WIDTH*HEIGHT-1:0] r_field_out;
    logic [CNT_W-1:0]        r_lines;

    logic                    w_row_full;
    logic [WIDTH*HEIGHT-1:0] w_collapsed;

    field_row_collapse #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_collapse (
        .fld           (r_fld),
        .ptr           (r_ptr),
        .row_full      (w_row_full),
        .fld_collapsed (w_collapsed)
    );

    // Controller: latch on start, test one row per cycle, publish results.
    // A full row keeps ptr in place so the row that dropped into it is
    // re-tested; the zero row injected at the top guarantees termination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LC_IDLE;
            r_fld       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_field_out <= '0;
            r_lines     <= '0;
        end else begin
            case (r_state)
                LC_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_fld   <= field_in;
                        r_ptr   <= PTR_W'(HEIGHT - 1);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= LC_SCAN;
                    end
                end
                LC_SCAN: begin
                    if (w_row_full) begin
                        r_fld <= w_collapsed;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (r_ptr == '0) begin
                        // Results are registered on entry so they are valid
                        // in the same cycle that done is high.
                        r_field_out <= r_fld;
                        r_lines     <= r_cnt;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= LC_DONE;
                    end else begin
                        r_ptr <= r_ptr - PTR_W'(1);
                    end
                end
                LC_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= LC_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= LC_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign field_out     = r_field_out;
    assign lines_cleared = r_lines;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_field_line_clear.sv
// Directed bench for field_line_clear: reset state, several clear patterns
// with hand-computed results and latencies, start-ignore and mid-pass reset.
module tb_field_line_clear;
    import tetris_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [FIELD_BITS-1:0] field_in;
    logic                  busy;
    logic                  done;
    logic [FIELD_BITS-1:0] field_out;
    logic [CNT_W-1:0]      lines_cleared;
    lc_state_t             dbg_state;

    int n_cmp;
    int n_fail;

    field_line_clear dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .field_in      (field_in),
        .busy          (busy),
        .done          (done),
        .field_out     (field_out),
        .lines_cleared (lines_cleared),
        .o_dbg_state   (dbg_state)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a field by writing one row value at row index r.
    function automatic logic [FIELD_BITS-1:0] put_row(
        input logic [FIELD_BITS-1:0] f,
        input int                    r,
        input logic [FIELD_W-1:0]    v
    );
        f[r*FIELD_W +: FIELD_W] = v;
        return f;
    endfunction

    // Driver: start high during cycle 0, low from cycle 1; returns in cycle 1.
    task automatic launch(input logic [FIELD_BITS-1:0] f);
        @(posedge clk); #1;
        field_in = f;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Driver: called in cycle 1, advances until done is seen or the budget ends.
    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        field_in = '1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (field_out !== '0) begin n_fail++; $display("FAIL reset_field_out got=%h exp=0", field_out); end
        n_cmp++; if (lines_cleared !== 5'd0) begin n_fail++; $display("FAIL reset_lines got=%0d exp=0", lines_cleared); end
        n_cmp++; if (dbg_state !== LC_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, LC_IDLE); end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_empty();
        int cyc; bit seen;
        launch('0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy_c1 got=%b exp=1", busy); end
        wait_done(cyc, seen);
        n_cmp++; if (!seen || cyc != 21) begin n_fail++; $display("FAIL empty_latency got=%0d seen=%b exp=21", cyc, seen); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_done got=%b exp=0", busy); end
        n_cmp++; if (field_out !== '0) begin n_fail++; $display("FAIL empty_field got=%h exp=0", field_out); end
        n_cmp++; if (lines_cleared !== 5'd0) begin n_fail++; $display("FAIL empty_lines got=%0d exp=0", lines_cleared); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_single_row();
        int cyc; bit seen;
        logic [FIELD_BITS-1:0] f, exp_f;
        f     = put_row(put_row('0, 19, 20'hFFFFF), 18, 20'h00001);
        exp_f = put_row('0, 19, 20'h00001);
        launch(f);
        wait_done(cyc, seen);
        n_cmp++; if (!seen || cyc != 22) begin n_fail++; $display("FAIL single_latency got=%0d seen=%b exp=22", cyc, seen); end
        n_cmp++; if (lines_cleared !== 5'd1) begin n_fail++; $display("FAIL single_lines got=%0d exp=1", lines_cleared); end
        n_cmp++; if (field_out !== exp_f) begin n_fail++; $display("FAIL single_field got=%h exp=%h", field_out, exp_f); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (field_out !== exp_f || lines_cleared !== 5'd1) begin
            n_fail++; $display("FAIL single_hold got=%h/%0d exp=%h/1", field_out, lines_cleared, exp_f);
        end
    endtask

    task automatic test_two_rows();
        int cyc; bit seen;
        logic [FIELD_BITS-1:0] f, exp_f;
        f = put_row('0, 19, 20'hFFFFF);
        f = put_row(f, 18, 20'h55555);
        f = put_row(f, 17, 20'hFFFFF);
        f = put_row(f, 16, 20'hAAAAA);
        exp_f = put_row(put_row('0, 19, 20'h55555), 18, 20'hAAAAA);
        launch(f);
        wait_done(cyc, seen);
        n_cmp++; if (!seen || cyc != 23) begin n_fail++; $display("FAIL two_latency got=%0d seen=%b exp=23", cyc, seen); end
        n_cmp++; if (lines_cleared !== 5'd2) begin n_fail++; $display("FAIL two_lines got=%0d exp=2", lines_cleared); end
        n_cmp++; if (field_out !== exp_f) begin n_fail++; $display("FAIL two_field got=%h exp=%h", field_out, exp_f); end
    endtask

    task automatic test_all_full();
        int cyc; bit seen;
        launch('1);
        wait_done(cyc, seen);
        n_cmp++; if (!seen || cyc != 41) begin n_fail++; $display("FAIL full_latency got=%0d seen=%b exp=41", cyc, seen); end
        n_cmp++; if (lines_cleared !== 5'd20) begin n_fail++; $display("FAIL full_lines got=%0d exp=20", lines_cleared); end
        n_cmp++; if (field_out !== '0) begin n_fail++; $display("FAIL full_field got=%h exp=0", field_out); end
    endtask

    task automatic test_start_ignored();
        int cyc, first_cyc, n_done;
        logic [FIELD_BITS-1:0] f, exp_f;
        f     = put_row(put_row('0, 19, 20'hFFFFF), 18, 20'h00001);
        exp_f = put_row('0, 19, 20'h00001);
        launch(f);
        cyc = 1; first_cyc = -1; n_done = 0;
        while (cyc < 70) begin
            if (cyc == 5) begin
                start    = 1'b1;
                field_in = '1;
            end
            if (cyc == 6) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        n_cmp++; if (first_cyc != 22) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=22", first_cyc); end
        n_cmp++; if (field_out !== exp_f || lines_cleared !== 5'd1) begin
            n_fail++; $display("FAIL ignore_result got=%h/%0d exp=%h/1", field_out, lines_cleared, exp_f);
        end
    endtask

    task automatic test_reset_mid_pass();
        int cyc, n_done; bit seen;
        logic [FIELD_BITS-1:0] f, exp_f;
        launch('1);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (field_out !== '0 || lines_cleared !== 5'd0) begin
            n_fail++; $display("FAIL midrst_outputs got=%h/%0d exp=0/0", field_out, lines_cleared);
        end
        n_cmp++; if (dbg_state !== LC_IDLE) begin n_fail++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, LC_IDLE); end
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        n_cmp++; if (n_done != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", n_done); end
        f     = put_row(put_row('0, 19, 20'hFFFFF), 10, 20'h0F0F0);
        exp_f = put_row('0, 11, 20'h0F0F0);
        launch(f);
        wait_done(cyc, seen);
        n_cmp++; if (!seen || cyc != 22) begin n_fail++; $display("FAIL midrst_restart_latency got=%0d seen=%b exp=22", cyc, seen); end
        n_cmp++; if (field_out !== exp_f || lines_cleared !== 5'd1) begin
            n_fail++; $display("FAIL midrst_restart_result got=%h/%0d exp=%h/1", field_out, lines_cleared, exp_f);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        field_in = '0;
        test_reset();
        test_empty();
        test_single_row();
        test_two_rows();
        test_all_full();
        test_start_ignored();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/field_line_clear.md
# field_line_clear

Post-lock line-clear engine for the playfield. When a piece locks, the controller hands this block the merged field (the `field_display` produced by the merge stage). The block scans every row bottom-up, deletes each completely filled row and collapses the rows above it. It then returns the compacted field, to be used as the next `field_background`, together with the number of lines removed.

## Interface
Parameters:
- `WIDTH`, 20: columns per row.
- `HEIGHT`, 20: rows in the field. `WIDTH*HEIGHT` must equal 400.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: request a clear pass on `field_in`. Sampled only in IDLE.
- `field_in`, input, 400: merged field. Row r occupies `[r*WIDTH +: WIDTH]`, row 0 is the top, and bit c of a row is column c.
- `busy`, output, 1: high while a pass is in progress.
- `done`, output, 1: one-cycle pulse when `field_out` and `lines_cleared` are valid.
- `field_out`, output, 400: compacted field, same layout as `field_in`.
- `lines_cleared`, output, 5: number of rows removed in the last pass, 0..20.

## Operation
- State machine: IDLE, SCAN, DONE.
- **IDLE**
  - `start=1`: latch `field_in` into the working register `fld`, set `ptr=HEIGHT-1`, clear `cnt`, go to SCAN.
  - `start=0`: stay in IDLE.
- **SCAN**, one row test per cycle on row `ptr` of `fld`:
  - Row is full (all WIDTH bits set): rows k=ptr..1 take row k-1, row 0 becomes all zeros, and `cnt++`. `ptr` is unchanged, so the same index is re-tested next cycle with the row that dropped into it.
  - Row is not full and `ptr==0`: go to DONE.
  - Row is not full and `ptr>0`: decrement `ptr`.
  - The scan always terminates because the injected top row is zero.
- **DONE**: latch `fld` into `field_out` and `cnt` into `lines_cleared`, pulse `done`, return to IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- `field_out` and `lines_cleared` hold their values from one DONE until the next DONE.
- Widths:
  - `ptr` is 5 bits.
  - `cnt` is 5 bits and cannot exceed HEIGHT. An all-full field removes all 20 rows.
  - Partial rows and empty rows are never altered except by being shifted down.

## Timing
- Reset values:
  - Outputs: `busy=0`, `done=0`, `field_out=0`, `lines_cleared=0`.
  - Internal: state IDLE, `fld=0`, `ptr=0`, `cnt=0`.
- `start` high in cycle 0 (in IDLE): `busy=1` in cycles 1..HEIGHT+n, where n is the number of rows removed.
- `done=1` and `busy=0` in cycle HEIGHT+n+1. Outputs are valid in that same cycle.
- The earliest next accepted `start` is in cycle HEIGHT+n+2.
- Latency examples:
  - Empty field: done in cycle 21.
  - Single full row: done in cycle 22.
  - All-full field: done in cycle 41.
- Reset asserted mid-pass: in the next cycle the block is in IDLE with all outputs at their reset values. No `done` is issued for the aborted pass.
- `start` and `rst_n=0` in the same cycle: reset wins.

## Structure
- Shared package `tetris_pkg` holds:
  - `FIELD_W=20`, `FIELD_H=20`, `FIELD_BITS=400`;
  - the state encodings `LC_IDLE`, `LC_SCAN`, `LC_DONE`;
  - the row-slice convention, shared with the merge stage and its index mapping.
- Sub-module `field_row_collapse` is combinational. Inputs `fld` and `ptr`; outputs `row_full` and the collapsed field.
  - It keeps the 20-way shift mux out of the FSM.
  - It is unit-testable on its own.

## Test plan
- Empty field, `start` pulse:
  - `done` in cycle 21;
  - `field_out=0`, `lines_cleared=0`.
- Row 19 all ones, row 18 = `20'h00001`, other rows zero:
  - `done` in cycle 22, `lines_cleared=1`;
  - row 19 of `field_out` = `20'h00001`, all other rows 0.
- Rows 17 and 19 full, row 16 = `20'hAAAAA`, row 18 = `20'h55555`:
  - `lines_cleared=2`, done in cycle 23;
  - row 19 = `20'h55555`, row 18 = `20'hAAAAA`, rest 0.
- All 400 bits set:
  - `lines_cleared=20`, `field_out=0`, done in cycle 41.
- Second `start` pulsed in cycle 5 of a pass: ignored, and exactly one `done`. Separately, `rst_n=0` in cycle 10 of a pass: no `done`, outputs 0, and a fresh `start` afterwards completes normally.
